// File: rtl/req_ack_pkg.sv
`default_nettype none
// ============================================================================
// Module : req_ack_pkg
// Brief  : Shared types and constants for the 2-phase REQ/ACK sender slice.
// Rev    : 1.0 - initial release
// ============================================================================
package req_ack_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // Index width for a requester pool; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// Module : cdc_sync_bit
// Brief  : Multi-flop single-bit synchronizer for level/toggle signals.
// Rev    : 1.0 - initial release
// ============================================================================
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/req_ack_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : req_ack_tx_arbiter
// Brief  : Round-robin arbiter feeding one 2-phase REQ/ACK CDC sender channel.
// Rev    : 1.0 - initial release
// ============================================================================
module req_ack_tx_arbiter
  import req_ack_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DWIDTH      = 8,
  parameter int IDW         = ptr_width(NREQ),
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk1,
  input  logic                   rst1_n,
  input  logic [NREQ-1:0]        in_valid,
  output logic [NREQ-1:0]        in_ready,
  input  logic [NREQ*DWIDTH-1:0] in_data,
  output logic                   req,
  input  logic                   ack_async,
  output logic [IDW+DWIDTH-1:0]  dout,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   timeout_err,
  output logic                   protocol_err,
  input  logic                   err_clr
);

  localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] C_TO_MAX  = CW'(TIMEOUT);

  // Returns {found, index}; the lowest offset from the pointer wins.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(p) + k) % NREQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_ack_s;
  logic                    r_ack_q;
  logic                    w_ack_edge;
  logic [IDW-1:0]          r_ptr;
  logic [CW-1:0]           r_cnt;
  logic                    r_req;
  logic [IDW+DWIDTH-1:0]   r_dout;
  logic [IDW-1:0]          r_grant;
  logic                    r_terr;
  logic                    r_perr;
  logic [IDW:0]            w_pick;
  logic                    w_win_vld;
  logic [IDW-1:0]          w_win_idx;
  logic [DWIDTH-1:0]       w_win_data;
  logic                    w_accept;
  logic                    w_to_hit;
  logic                    w_spurious;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk1),
    .rst_n (rst1_n),
    .d     (ack_async),
    .q     (w_ack_s)
  );

  assign w_ack_edge = w_ack_s ^ r_ack_q;
  assign w_pick     = rr_pick(in_valid, r_ptr);
  assign w_win_vld  = w_pick[IDW];
  assign w_win_idx  = w_pick[IDW-1:0];
  assign w_win_data = in_data[w_win_idx*DWIDTH +: DWIDTH];
  assign w_accept   = (r_state == ST_IDLE) && w_win_vld;
  assign w_spurious = (r_state == ST_IDLE) && w_ack_edge;
  // A completing ack in the deadline cycle takes priority over the timeout.
  assign w_to_hit   = (TIMEOUT > 0) && (r_state == ST_WAIT) &&
                      (r_cnt == C_TO_LAST) && !w_ack_edge;

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)   w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_ack_edge) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    busy     = (r_state == ST_WAIT);
    if (w_accept) in_ready[w_win_idx] = 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      r_ack_q <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_dout  <= '0;
      r_grant <= '0;
      r_terr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_ack_q <= w_ack_s;
      if (w_accept) begin
        r_req   <= ~r_req;
        r_dout  <= {w_win_idx, w_win_data};
        r_grant <= w_win_idx;
        r_ptr   <= (w_win_idx == IDW'(NREQ - 1)) ? '0 : w_win_idx + 1'b1;
        r_cnt   <= '0;
      end else if (r_state == ST_WAIT) begin
        if (w_ack_edge) begin
          r_cnt <= '0;
        end else if (r_cnt != C_TO_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_to_hit) begin
        r_terr <= 1'b1;
      end else if (err_clr) begin
        r_terr <= 1'b0;
      end
      if (w_spurious) begin
        r_perr <= 1'b1;
      end else if (err_clr) begin
        r_perr <= 1'b0;
      end
    end
  end

  assign req          = r_req;
  assign dout         = r_dout;
  assign grant_id     = r_grant;
  assign timeout_err  = r_terr;
  assign protocol_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_req_ack_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_req_ack_tx_arbiter
// Brief  : Directed self-checking bench with a per-cycle reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_req_ack_tx_arbiter;

  localparam int NREQ   = 4;
  localparam int DWIDTH = 8;
  localparam int IDW    = 2;
  localparam int SS     = 2;
  localparam int TO     = 16;
  localparam int DW     = IDW + DWIDTH;

  logic                   clk1 = 1'b0;
  logic                   rst1_n;
  logic [NREQ-1:0]        in_valid;
  logic [NREQ-1:0]        in_ready;
  logic [NREQ*DWIDTH-1:0] in_data;
  logic                   req;
  logic                   ack_async;
  logic [DW-1:0]          dout;
  logic                   busy;
  logic [IDW-1:0]         grant_id;
  logic                   timeout_err;
  logic                   protocol_err;
  logic                   err_clr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_tog = 0;
  logic req_prev = 1'b0;
  logic [DWIDTH-1:0] data_of [NREQ];

  always #5 clk1 = ~clk1;

  req_ack_tx_arbiter #(
    .NREQ        (NREQ),
    .DWIDTH      (DWIDTH),
    .SYNC_STAGES (SS),
    .TIMEOUT     (TO)
  ) dut (
    .clk1         (clk1),
    .rst1_n       (rst1_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .req          (req),
    .ack_async    (ack_async),
    .dout         (dout),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err),
    .err_clr      (err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Reference model: ack history as a list of past samples, WAIT length as a plain count.
  logic          m_req, m_busy, m_terr, m_perr;
  logic [DW-1:0] m_dout;
  int            m_grant, m_ptr, m_waitn;
  logic          m_hist [0:SS];

  always @(posedge clk1 or negedge rst1_n) begin
    int   win;
    logic ack_ev, tset, pset;
    if (!rst1_n) begin
      m_req = 0; m_busy = 0; m_terr = 0; m_perr = 0; m_dout = '0;
      m_grant = 0; m_ptr = 0; m_waitn = 0;
      for (int k = 0; k <= SS; k++) m_hist[k] = 1'b0;
    end else begin
      ack_ev = m_hist[SS-1] ^ m_hist[SS];
      tset = 0; pset = 0;
      if (!m_busy) begin
        if (ack_ev) pset = 1;
        win = pick(in_valid, m_ptr);
        if (win >= 0) begin
          m_req   = ~m_req;
          m_dout  = {win[IDW-1:0], in_data[win*DWIDTH +: DWIDTH]};
          m_grant = win;
          m_ptr   = (win + 1) % NREQ;
          m_busy  = 1;
          m_waitn = 0;
        end
      end else begin
        m_waitn++;
        if (ack_ev) m_busy = 0;
        else if (m_waitn == TO) tset = 1;
      end
      m_terr = tset | (m_terr & ~err_clr);
      m_perr = pset | (m_perr & ~err_clr);
      for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = ack_async;
    end
  end

  always @(negedge clk1) begin
    logic [NREQ-1:0] exp_rdy;
    int w;
    if (rst1_n === 1'b1) begin
      exp_rdy = '0;
      w = m_busy ? -1 : pick(in_valid, m_ptr);
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("m_req", 32'(req), 32'(m_req));
      chk("m_dout", 32'(dout), 32'(m_dout));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_grant", 32'(grant_id), 32'(m_grant[IDW-1:0]));
      chk("m_terr", 32'(timeout_err), 32'(m_terr));
      chk("m_perr", 32'(protocol_err), 32'(m_perr));
      chk("m_ready", 32'(in_ready), 32'(exp_rdy));
      if (req !== req_prev) n_tog++;
    end
    req_prev = req;
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic xfer(input int exp_id, input int dly, input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_grant"}, 32'(grant_id), 32'(exp_id));
    chk({tag, "_dout"}, 32'(dout), 32'({exp_id[IDW-1:0], data_of[exp_id]}));
    repeat (dly) tick();
    ack_async = ~ack_async;
    wait_idle({tag, "_done"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tog0;
    rst1_n = 0; in_valid = '0; in_data = '0; ack_async = 0; err_clr = 0;
    for (int i = 0; i < NREQ; i++) data_of[i] = 8'h0F + 8'h10 * 8'(i);
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_perr", 32'(protocol_err), 32'd0);
    @(posedge clk1); #1 rst1_n = 1;
    tick(); tick();

    // Single requester 2 with 0xA5
    in_data[2*DWIDTH +: DWIDTH] = 8'hA5;
    in_valid = 4'b0100;
    #1 chk("t1_ready", 32'(in_ready), 32'h4);
    tick();
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_dout", 32'(dout), 32'h2A5);
    chk("t1_busy", 32'(busy), 32'd1);
    in_valid = '0;
    repeat (5) tick();
    ack_async = 1;
    repeat (SS + 1) begin
      @(negedge clk1);
      chk("t1_busy_hold", 32'(busy), 32'd1);
    end
    @(negedge clk1);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    #1 in_valid = 4'b0100;
    #1 chk("t1_ready_again", 32'(in_ready), 32'h4);
    tick();
    chk("t1_req2", 32'(req), 32'd0);
    chk("t1_dout2", 32'(dout), 32'h2A5);
    in_valid = '0;
    repeat (3) tick();
    ack_async = 0;
    wait_idle("t1_done2");

    // Fresh start so the pointer is at 0, then 8 back-to-back transfers
    rst1_n = 0; ack_async = 0;
    tick(); tick();
    rst1_n = 1;
    tick();
    for (int i = 0; i < NREQ; i++) in_data[i*DWIDTH +: DWIDTH] = data_of[i];
    tog0 = n_tog;
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) xfer(k % NREQ, 2, "t2");
    in_valid = '0;
    tick();
    chk("t2_toggles", 32'(n_tog - tog0), 32'd8);

    // Park the pointer at 2, then only requesters 1 and 3 compete
    in_valid = 4'b0010;
    xfer(1, 1, "t3a");
    in_valid = 4'b1010;
    xfer(3, 1, "t3b");
    xfer(1, 1, "t3c");
    in_valid = '0;
    tick();

    // Ack withheld past the timeout
    in_valid = 4'b0001;
    tick();
    chk("t4_busy", 32'(busy), 32'd1);
    in_valid = '0;
    repeat (15) tick();
    chk("t4_terr_early", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_terr_set", 32'(timeout_err), 32'd1);
    repeat (24) tick();
    ack_async = ~ack_async;
    wait_idle("t4_done");
    chk("t4_terr_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    chk("t4_terr_clr", 32'(timeout_err), 32'd0);

    // Spurious ack while idle, then clear colliding with a new spurious edge
    ack_async = ~ack_async;
    repeat (4) tick();
    chk("t5_perr", 32'(protocol_err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    ack_async = ~ack_async;
    tick(); tick();
    err_clr = 1; tick(); err_clr = 0;
    chk("t5_perr_setwins", 32'(protocol_err), 32'd1);
    err_clr = 1; tick(); err_clr = 0;
    chk("t5_perr_clr", 32'(protocol_err), 32'd0);

    // Reset in the middle of WAIT, receiver reset alongside
    in_valid = 4'b0100;
    tick();
    in_valid = '0;
    tick(); tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    rst1_n = 0; ack_async = 0;
    #1 chk("t6_req_rst", 32'(req), 32'd0);
    chk("t6_busy_rst", 32'(busy), 32'd0);
    tick();
    rst1_n = 1;
    tick();
    in_valid = 4'hF;
    xfer(0, 3, "t6");
    in_valid = '0;
    tick();
    chk("t6_terr", 32'(timeout_err), 32'd0);
    chk("t6_perr", 32'(protocol_err), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
